// File: rtl/axi_lite_master_pkg.sv
// AXI-lite response codes shared by the master and its bus neighbours.
package axi_lite_master_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite master: turns one user command into one AXI-lite
// read or write and hands the completion back on a valid/ready response port.
//
// state          | meaning
// IDLE           | o_cmd_ready high, waiting for a user command
// WR_ADDR_DATA   | AW and W offered independently until both have handshaked
// WR_RESP        | o_bready high, waiting for the write response
// RD_ADDR        | AR offered, waiting for i_arready
// RD_DATA        | o_rready high, waiting for the read data
// USER_RSP       | response held on o_rsp_* until the user takes it
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,

    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_rsp_err,

    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [ADDR_WIDTH-1:0] o_awaddr,

    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [DATA_WIDTH-1:0] o_wdata,

    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,

    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [ADDR_WIDTH-1:0] o_araddr,

    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_USER_RSP     = 3'd5
    } state_t;

    state_t                state;
    state_t                state_d;
    logic                  aw_done;
    logic                  aw_done_d;
    logic                  w_done;
    logic                  w_done_d;
    logic                  awvalid_d;
    logic                  wvalid_d;
    logic                  bready_d;
    logic                  arvalid_d;
    logic                  rready_d;
    logic                  rsp_valid_d;
    logic                  rsp_err_d;
    logic [1:0]            rsp_resp_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign o_cmd_ready = (state == ST_IDLE);

    // Handshakes only ever qualify on the master's own registered valid/ready,
    // so early or stray slave valids are simply not seen.
    assign aw_hs = o_awvalid && i_awready;
    assign w_hs  = o_wvalid  && i_wready;
    assign b_hs  = o_bready  && i_bvalid;
    assign ar_hs = o_arvalid && i_arready;
    assign r_hs  = o_rready  && i_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            o_awvalid   <= 1'b0;
            o_awaddr    <= '0;
            o_wvalid    <= 1'b0;
            o_wdata     <= '0;
            o_bready    <= 1'b0;
            o_arvalid   <= 1'b0;
            o_araddr    <= '0;
            o_rready    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= 2'b00;
            o_rsp_err   <= 1'b0;
        end else begin
            state       <= state_d;
            aw_done     <= aw_done_d;
            w_done      <= w_done_d;
            o_awvalid   <= awvalid_d;
            o_awaddr    <= awaddr_d;
            o_wvalid    <= wvalid_d;
            o_wdata     <= wdata_d;
            o_bready    <= bready_d;
            o_arvalid   <= arvalid_d;
            o_araddr    <= araddr_d;
            o_rready    <= rready_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_rdata <= rsp_rdata_d;
            o_rsp_resp  <= rsp_resp_d;
            o_rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        aw_done_d   = aw_done;
        w_done_d    = w_done;
        awvalid_d   = o_awvalid;
        awaddr_d    = o_awaddr;
        wvalid_d    = o_wvalid;
        wdata_d     = o_wdata;
        bready_d    = o_bready;
        arvalid_d   = o_arvalid;
        araddr_d    = o_araddr;
        rready_d    = o_rready;
        rsp_valid_d = o_rsp_valid;
        rsp_rdata_d = o_rsp_rdata;
        rsp_resp_d  = o_rsp_resp;
        rsp_err_d   = o_rsp_err;

        case (state)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (i_cmd_valid) begin
                    if (i_cmd_write) begin
                        awaddr_d  = i_cmd_addr;
                        wdata_d   = i_cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_ADDR_DATA;
                    end else begin
                        araddr_d  = i_cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end

            ST_WR_ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Leave as soon as the last of the two handshakes lands so a
                // fully ready slave sees B ready one cycle after AW/W.
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = i_bresp;
                    rsp_err_d   = resp_is_err(i_bresp);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_USER_RSP;
                end
            end

            ST_RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = i_rdata;
                    rsp_resp_d  = i_rresp;
                    rsp_err_d   = resp_is_err(i_rresp);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_USER_RSP;
                end
            end

            ST_USER_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                aw_done_d   = 1'b0;
                w_done_d    = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: behavioural AXI-lite slave with
// per-channel delays, memory reference model, directed cases then random traffic.
module tb_axi_lite_master;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_rsp_valid, i_rsp_ready, o_rsp_err;
    logic [DW-1:0] o_rsp_rdata;
    logic [1:0]    o_rsp_resp;
    logic          o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
    logic [AW-1:0] o_awaddr, o_araddr;
    logic [DW-1:0] o_wdata, i_rdata;
    logic [1:0]    i_bresp, i_rresp;
    logic          o_arvalid, i_arready, i_rvalid, o_rready;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp), .o_rsp_err(o_rsp_err),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- slave behaviour rules shared by slave and model ----------------
    function automatic logic [1:0] slave_resp(input logic [AW-1:0] a);
        return (a[11:8] == 4'h3) ? a[5:4] : 2'b00;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    bit            ovr_en = 0;
    logic [1:0]    ovr_resp = 2'b00;
    logic [DW-1:0] ovr_rdata = '0;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model_mem[logic [AW-1:0]];

    function automatic exp_t predict(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        if (wr) begin
            model_mem[a] = d;
            e.rdata = '0;
        end else if (ovr_en) begin
            e.rdata = ovr_rdata;
        end else begin
            e.rdata = model_mem.exists(a) ? model_mem[a] : fill(a);
        end
        e.resp = ovr_en ? ovr_resp : slave_resp(a);
        e.err  = (e.resp != 2'b00);
        return e;
    endfunction

    // ---------------- behavioural AXI-lite slave ----------------
    int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit            spurious_en = 0;
    int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit            aw_got, w_got, b_pend, r_pend;
    bit            aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n;
    logic [AW-1:0] s_awaddr, s_araddr, last_wr_addr;
    logic [DW-1:0] s_wdata, last_wr_data, r_data_cur;
    logic [1:0]    b_resp_cur, r_resp_cur;
    logic [DW-1:0] s_mem[logic [AW-1:0]];
    int unsigned   aw_hs_cyc, w_hs_cyc;
    int            b_cnt = 0;

    initial begin
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
        i_arready = 0; i_rvalid = 0; i_rdata = 0; i_rresp = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
                i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0;
                continue;
            end
            if (aw_hs_n) begin aw_got = 1; aw_wait = 0; end
            if (w_hs_n)  begin w_got = 1; w_wait = 0; end
            if (b_hs_n)  begin b_pend = 0; b_cnt++; end
            if (r_hs_n)  r_pend = 0;
            if (ar_hs_n) begin
                r_pend = 1; r_wait = 0;
                r_data_cur = ovr_en ? ovr_rdata : (s_mem.exists(s_araddr) ? s_mem[s_araddr] : fill(s_araddr));
                r_resp_cur = ovr_en ? ovr_resp : slave_resp(s_araddr);
            end
            if (aw_got && w_got) begin
                s_mem[s_awaddr] = s_wdata;
                last_wr_addr = s_awaddr;
                last_wr_data = s_wdata;
                b_resp_cur = ovr_en ? ovr_resp : slave_resp(s_awaddr);
                b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0;
            end

            i_awready = o_awvalid && !aw_got && (aw_wait >= aw_dly);
            if (o_awvalid && !aw_got && !i_awready) aw_wait++;
            i_wready = o_wvalid && !w_got && (w_wait >= w_dly);
            if (o_wvalid && !w_got && !i_wready) w_wait++;
            i_arready = o_arvalid && !r_pend && (ar_wait >= ar_dly);
            if (o_arvalid && !r_pend && !i_arready) ar_wait++;

            if (b_pend) begin
                i_bvalid = (b_wait >= b_dly);
                i_bresp  = b_resp_cur;
                if (!i_bvalid) b_wait++;
            end else begin
                i_bvalid = spurious_en && ($urandom_range(0, 3) == 0);
                i_bresp  = 2'($urandom);
            end
            if (r_pend) begin
                i_rvalid = (r_wait >= r_dly);
                i_rdata  = r_data_cur;
                i_rresp  = r_resp_cur;
                if (!i_rvalid) r_wait++;
            end else begin
                i_rvalid = spurious_en && ($urandom_range(0, 3) == 0);
                i_rdata  = $urandom;
                i_rresp  = 2'($urandom);
            end

            aw_hs_n = o_awvalid && i_awready;
            w_hs_n  = o_wvalid && i_wready;
            ar_hs_n = o_arvalid && i_arready;
            b_hs_n  = i_bvalid && o_bready && b_pend;
            r_hs_n  = i_rvalid && o_rready && r_pend;
            if (aw_hs_n) begin s_awaddr = o_awaddr; aw_hs_cyc = cyc; end
            if (w_hs_n)  begin s_wdata = o_wdata; w_hs_cyc = cyc; end
            if (ar_hs_n) s_araddr = o_araddr;
        end
    end

    // ---------------- response monitor / protocol stability ----------------
    int            hold_left = 0;
    bit            rand_ready = 0;
    int unsigned   rsp_rise_cyc, rsp_hs_cyc;
    int            aw_vcycles = 0, w_vcycles = 0;
    bit            p_aw, p_w, p_ar, p_rsp;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic [1:0]    p_resp;
    logic          p_err, p_rsp_valid;

    initial begin
        exp_t e;
        i_rsp_ready = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0; p_rsp_valid = 0;
        forever begin
            @(negedge clk);
            if (o_rsp_valid && hold_left > 0) begin
                i_rsp_ready = 0;
                hold_left--;
            end else begin
                i_rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            if (!rst) begin
                p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0; p_rsp_valid = 0;
                continue;
            end
            if (p_aw) begin
                check("awvalid_held", o_awvalid, 1);
                check("awaddr_stable", o_awaddr, p_awaddr);
            end
            if (p_w) begin
                check("wvalid_held", o_wvalid, 1);
                check("wdata_stable", o_wdata, p_wdata);
            end
            if (p_ar) begin
                check("arvalid_held", o_arvalid, 1);
                check("araddr_stable", o_araddr, p_araddr);
            end
            if (p_rsp) begin
                check("rsp_valid_held", o_rsp_valid, 1);
                check("rsp_rdata_stable", o_rsp_rdata, p_rdata);
                check("rsp_resp_stable", o_rsp_resp, p_resp);
                check("rsp_err_stable", o_rsp_err, p_err);
            end
            if (o_awvalid) aw_vcycles++;
            if (o_wvalid) w_vcycles++;
            if (o_rsp_valid && !p_rsp_valid) rsp_rise_cyc = cyc;
            if (o_rsp_valid && i_rsp_ready) begin
                if (sb_q.size() == 0) begin
                    timeout("rsp_without_command");
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", o_rsp_rdata, e.rdata);
                    check("rsp_resp", o_rsp_resp, e.resp);
                    check("rsp_err", o_rsp_err, e.err);
                end
                rsp_hs_cyc = cyc;
            end
            p_aw = o_awvalid && !i_awready;   p_awaddr = o_awaddr;
            p_w  = o_wvalid && !i_wready;     p_wdata  = o_wdata;
            p_ar = o_arvalid && !i_arready;   p_araddr = o_araddr;
            p_rsp = o_rsp_valid && !i_rsp_ready;
            p_rdata = o_rsp_rdata; p_resp = o_rsp_resp; p_err = o_rsp_err;
            p_rsp_valid = o_rsp_valid;
        end
    end

    // ---------------- stimulus ----------------
    int unsigned cmd_hs_cyc;

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit keep_valid);
        int t = 0;
        i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = a; i_cmd_wdata = d;
        while (!o_cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_cmd_ready) begin
            timeout("cmd_accept");
            i_cmd_valid = 0;
            return;
        end
        cmd_hs_cyc = cyc;
        sb_q.push_back(predict(wr, a, d));
        @(negedge clk);
        if (!keep_valid) i_cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || !o_cmd_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0 || !o_cmd_ready) timeout("wait_idle");
    endtask

    task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        int t;
        int bc;
        int unsigned c0, rh;
        i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_wdata = 0;
        rst = 0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_rsp_valid}, 0);
        check("rst_readies", {o_bready, o_rready}, 0);
        check("rst_addrs", {o_awaddr, o_araddr}, 0);
        check("rst_wdata", o_wdata, 0);
        check("rst_rsp_payload", {o_rsp_rdata, o_rsp_resp, o_rsp_err}, 0);
        rst = 1;
        @(negedge clk);
        check("cmd_ready_after_release", o_cmd_ready, 1);

        // Write with everything ready: AW and W on the same edge, 3-cycle latency
        set_dly(0, 0, 0, 0, 0);
        send_cmd(1, 16'h0010, 32'hDEADBEEF, 0);
        c0 = cmd_hs_cyc;
        wait_idle();
        check("wr_aw_cycle", aw_hs_cyc, c0 + 1);
        check("wr_w_cycle", w_hs_cyc, c0 + 1);
        check("wr_slave_addr", last_wr_addr, 16'h0010);
        check("wr_slave_data", last_wr_data, 32'hDEADBEEF);
        check("wr_latency", rsp_rise_cyc - c0, 3);

        // AW ready delayed 3 cycles, W immediate
        set_dly(3, 0, 0, 0, 0);
        aw_vcycles = 0; w_vcycles = 0; bc = b_cnt;
        send_cmd(1, 16'h0104, 32'h0BADF00D, 0);
        wait_idle();
        check("slow_aw_awvalid_cycles", aw_vcycles, 4);
        check("slow_aw_wvalid_cycles", w_vcycles, 1);
        check("slow_aw_b_handshakes", b_cnt - bc, 1);

        // Read with DECERR and forced data
        set_dly(0, 0, 0, 0, 0);
        ovr_en = 1; ovr_resp = 2'b11; ovr_rdata = 32'h12345678;
        send_cmd(0, 16'h0020, 32'h0, 0);
        c0 = cmd_hs_cyc;
        wait_idle();
        ovr_en = 0;
        check("rd_latency", rsp_rise_cyc - c0, 3);

        // Response held off 5 cycles, then back-to-back read with cmd_valid held
        hold_left = 5;
        send_cmd(1, 16'h0040, 32'hA5A55A5A, 1);
        i_cmd_write = 0; i_cmd_addr = 16'h0040;
        t = 0;
        while (!o_rsp_valid && t < 50) begin @(negedge clk); t++; end
        if (!o_rsp_valid) timeout("held_rsp_appear");
        repeat (5) begin
            check("held_cmd_ready_low", o_cmd_ready, 0);
            @(negedge clk);
        end
        send_cmd(0, 16'h0040, 32'h0, 0);
        rh = rsp_hs_cyc;
        check("b2b_accept_gap", cmd_hs_cyc - rh, 1);
        wait_idle();

        // Reset while waiting for B
        set_dly(0, 0, 4, 0, 0);
        send_cmd(1, 16'h0080, 32'hCAFE0001, 0);
        t = 0;
        while (!o_bready && t < 50) begin @(negedge clk); t++; end
        if (!o_bready) timeout("reach_wr_resp");
        #2 rst = 0;
        #1;
        check("midrst_valids", {o_awvalid, o_wvalid, o_arvalid, o_rsp_valid}, 0);
        check("midrst_readies", {o_bready, o_rready}, 0);
        check("midrst_cmd_ready", o_cmd_ready, 1);
        sb_q.delete();
        @(negedge clk);
        #3 rst = 1;
        @(negedge clk);
        check("post_rst_cmd_ready", o_cmd_ready, 1);
        set_dly(0, 0, 0, 0, 0);
        send_cmd(0, 16'h0080, 32'h0, 0);
        wait_idle();

        // Random traffic with stray B/R valids and random user back-pressure
        spurious_en = 1;
        rand_ready = 1;
        for (int n = 0; n < 250; n++) begin
            logic [AW-1:0] a;
            a = AW'((($urandom_range(2, 3)) << 8) | (($urandom_range(0, 15)) << 2));
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            send_cmd($urandom_range(0, 1) == 1, a, $urandom, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_idle();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
